cpu_step_sequencer: RTL
=======================

// Module: cpu_step_sequencer
// PURPOSE
//  Sequences the single-cycle CPU datapath (PC, instruction ROM, register file, data RAM, ULA).
//  Replaces the free 1 Hz clock divider: everything runs on clk; emits one-cycle enables.
//  Waits out synchronous ROM/RAM read latency, supports free-run, single-step, breakpoint and halt.
//  Feeds the PC enable, register-file write gate and data-RAM write gate; status goes to LEDs/LCD.
// PARAMETERS
//  RUN_DIV    50_000_000   clk cycles between run-mode triggers (1 Hz at 50 MHz); >= 8
//  DEB_CYC    500_000      cycles step_n must be stable to count as pressed (10 ms)
//  ROM_LAT    2            cycles from PC change to valid inst; >= 1
//  RAM_LAT    2            cycles from ALU address to valid RAM read data; >= 1
//  HALT_WORD  32'hFC00_0000 instruction encoding that halts the CPU
//  CNT_W      16           width of retired-instruction counter
// PORTS
//  clk         in   1      system clock (CLOCK_50)
//  rst         in   1      synchronous, active-high reset
//  run_sw      in   1      1 = free-run at RUN_DIV rate, 0 = single-step mode
//  step_n      in   1      raw step key, active-low, asynchronous/bouncy
//  bp_en       in   1      breakpoint enable
//  bp_addr     in   8      breakpoint PC value
//  pc          in   8      current PC from PC register
//  inst        in   32     instruction word from ROM
//  mem_access  in   1      decoded MemtoReg | MemWrite of current inst
//  pc_en       out  1      one-cycle PC load enable
//  rf_we_en    out  1      one-cycle gate ANDed with RegWrite
//  dm_we_en    out  1      one-cycle gate ANDed with MemWrite
//  state_o     out  3      current FSM state encoding
//  halted      out  1      1 in BP_HALT or HALTED
//  retired     out  CNT_W  committed instructions, saturating
// BEHAVIOUR
//  Reset: state IDLE-fetch (FETCH, counter reloaded), all enables 0, halted 0, retired 0,
//   prescaler 0, debouncer cleared. Reset mid-instruction aborts with no commit.
//  States: FETCH, IDLE, MEMW, COMMIT, BP_HALT, HALTED.
//  FETCH: wait ROM_LAT cycles after entry; then inst==HALT_WORD -> HALTED (no commit);
//   else -> IDLE.
//  IDLE: checks, in priority order:
//   bp_en && pc==bp_addr && !bp_skip -> BP_HALT;
//   trigger -> MEMW if mem_access else COMMIT.
//   trigger = prescaler wrap when run_sw=1; debounced press edge when run_sw=0.
//  MEMW: wait RAM_LAT cycles, then COMMIT.
//  COMMIT: exactly one cycle with pc_en=rf_we_en=dm_we_en=1; retired += 1 (holds at all-ones);
//   clear bp_skip; -> FETCH.
//  BP_HALT: halted=1; press edge (either mode) sets bp_skip and -> IDLE;
//   next IDLE executes the bp instruction on a trigger.
//  HALTED: halted=1, terminal until rst; presses ignored.
//  Enables are 0 in every state except COMMIT; never two COMMITs without a FETCH between.
//  Prescaler free-runs 0..RUN_DIV-1; triggers/presses arriving outside IDLE or BP_HALT dropped.
//  run_sw change mid-instruction: current instruction completes; new mode applies in IDLE.
//  In run mode presses are ignored except in BP_HALT. PC wrap 255->0 is datapath's concern.
//  Debounce: 2-FF synchroniser, counter restarts on any change; press edge = stable 1->0 on step_n.
// STRUCTURE
//  cpu_ctrl_pkg: state encodings (3-bit localparams), default HALT_WORD.
//  Sub-module key_debounce (sync + stable counter + falling-edge pulse), param DEB_CYC.
//  Top: FSM, shared latency counter (max(ROM_LAT,RAM_LAT) wide), prescaler, retired counter.
// TESTING
//  (bench params: RUN_DIV=8, DEB_CYC=4, ROM_LAT=2, RAM_LAT=2, CNT_W=4)
//  Reset, run_sw=1, inst=0 ALU op, mem_access=0 -> pc_en pulses once per 8 clk;
//   each pulse is 1 cycle wide; retired counts 1,2,3.
//  run_sw=0, step_n bounced 3 cycles then held low 6 -> exactly one pc_en; release/press again -> second pc_en.
//  mem_access=1 step -> pc_en appears >= 2 cycles later than for mem_access=0 (MEMW dwell); dm_we_en coincident.
//  bp_en=1, bp_addr=5, pc reaches 5 -> halted=1, no pc_en for 40 cycles;
//   one press -> one commit, halted=0, runs on.
//  inst=32'hFC00_0000 after FETCH -> halted=1, state HALTED, pc_en never again;
//   presses ignored; rst returns halted=0, retired=0.
//  rst asserted in MEMW -> next cycle enables 0, no commit; retired saturates at 4'hF after 20 commits.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encodings and defaults for the CPU step sequencer
package cpu_ctrl_pkg;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_MEMW    = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_BP_HALT = 3'd4,
    ST_HALTED  = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_step_sequencer_key_debounce.sv
// rtl/cpu_step_sequencer_key_debounce.sv - step key synchroniser, stability filter and press pulse
module key_debounce #(
  parameter int DEB_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic          sync1;
  logic          sync2;
  logic          last;
  logic          stable;
  logic [CW-1:0] cnt;

  // Released level is 1; any change on the synchronised key restarts the stability count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      last   <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != last) begin
        last <= sync2;
        cnt  <= '0;
      end else if (cnt != CW'(DEB_CYC - 1)) begin
        cnt <= cnt + CW'(1);
      end else if (stable != last) begin
        stable <= last;
        press  <= stable & ~last;
      end
    end
  end

endmodule

// File: rtl/cpu_step_sequencer.sv
// rtl/cpu_step_sequencer.sv - paces the single-cycle datapath with one-cycle commit enables
module cpu_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int          RUN_DIV   = 50_000_000,
  parameter int          DEB_CYC   = 500_000,
  parameter int          ROM_LAT   = 2,
  parameter int          RAM_LAT   = 2,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_sw,
  input  logic             step_n,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pc,
  input  logic [31:0]      inst,
  input  logic             mem_access,
  output logic             pc_en,
  output logic             rf_we_en,
  output logic             dm_we_en,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int LAT_MAX = (ROM_LAT > RAM_LAT) ? ROM_LAT : RAM_LAT;
  localparam int LW      = $clog2(LAT_MAX + 1);
  localparam int PW      = $clog2(RUN_DIV);

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] lat_cnt;
  logic [PW-1:0] presc;
  logic          bp_skip;
  logic          press;
  logic          tick;
  logic          trigger;
  logic          commit;

  key_debounce #(.DEB_CYC(DEB_CYC)) u_key (
    .clk   (clk),
    .rst   (rst),
    .key_n (step_n),
    .press (press)
  );

  assign tick    = (presc == PW'(RUN_DIV - 1));
  assign trigger = run_sw ? tick : press;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      // Instruction word is only trusted once ROM_LAT edges have passed since the PC moved.
      ST_FETCH: begin
        if (lat_cnt == LW'(ROM_LAT))
          state_nxt = (inst == HALT_WORD) ? ST_HALTED : ST_IDLE;
      end
      ST_IDLE: begin
        if (bp_en && (pc == bp_addr) && !bp_skip)
          state_nxt = ST_BP_HALT;
        else if (trigger)
          state_nxt = mem_access ? ST_MEMW : ST_COMMIT;
      end
      ST_MEMW: begin
        if (lat_cnt == LW'(RAM_LAT - 1))
          state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_BP_HALT: begin
        if (press)
          state_nxt = ST_IDLE;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      lat_cnt <= '0;
      presc   <= '0;
      bp_skip <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state_nxt != state) ? '0 : lat_cnt + LW'(1);
      presc   <= tick ? '0 : presc + PW'(1);
      if (state == ST_BP_HALT && press)
        bp_skip <= 1'b1;
      if (commit) begin
        bp_skip <= 1'b0;
        if (~&retired)
          retired <= retired + CNT_W'(1);
      end
    end
  end

  assign pc_en    = commit;
  assign rf_we_en = commit;
  assign dm_we_en = commit;
  assign state_o  = state;
  assign halted   = (state == ST_BP_HALT) || (state == ST_HALTED);

endmodule
